// File: rtl/alu_issue_stage_if.sv
// Handshake/bus bundle between the ID-side producers and the ALU issue stage.
// The issue stage uses the slave modport. The ID and hazard side uses master.
interface alu_issue_stage_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 4
);
  logic                  id_valid_i;
  logic                  stall_i;
  logic                  flush_i;
  logic [2:0]            alu_op_i;
  logic [5:0]            funct_i;
  logic [4:0]            shamt_i;
  logic                  alu_src_i;
  logic [DATA_WIDTH-1:0] rs_data_i;
  logic [DATA_WIDTH-1:0] rt_data_i;
  logic [DATA_WIDTH-1:0] imm_i;
  logic [1:0]            fwd_a_sel_i;
  logic [1:0]            fwd_b_sel_i;
  logic [DATA_WIDTH-1:0] exmem_result_i;
  logic [DATA_WIDTH-1:0] memwb_result_i;

  logic                  ex_valid_o;
  logic [OP_WIDTH-1:0]   alu_operation_o;
  logic [DATA_WIDTH-1:0] alu_a_o;
  logic [DATA_WIDTH-1:0] alu_b_o;
  logic [4:0]            alu_shamt_o;
  logic [DATA_WIDTH-1:0] store_data_o;
  logic                  illegal_op_o;

  modport master (
    output id_valid_i, stall_i, flush_i, alu_op_i, funct_i, shamt_i, alu_src_i,
           rs_data_i, rt_data_i, imm_i, fwd_a_sel_i, fwd_b_sel_i,
           exmem_result_i, memwb_result_i,
    input  ex_valid_o, alu_operation_o, alu_a_o, alu_b_o, alu_shamt_o,
           store_data_o, illegal_op_o
  );

  modport slave (
    input  id_valid_i, stall_i, flush_i, alu_op_i, funct_i, shamt_i, alu_src_i,
           rs_data_i, rt_data_i, imm_i, fwd_a_sel_i, fwd_b_sel_i,
           exmem_result_i, memwb_result_i,
    output ex_valid_o, alu_operation_o, alu_a_o, alu_b_o, alu_shamt_o,
           store_data_o, illegal_op_o
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage feeding the 32-bit ALU. It decodes ALUOp and funct into an
// ALUOperation code, registers the operands, and applies EX-stage forwarding.
module alu_issue_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  alu_issue_stage_if.slave bus
);

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_NOR = 4'b0010,
    OP_ADD = 4'b0011,
    OP_SUB = 4'b0100,
    OP_LUI = 4'b0101,
    OP_SLL = 4'b0110,
    OP_SRL = 4'b0111,
    OP_NOP = 4'b1111
  } alu_oper_e;

  typedef enum logic [2:0] {
    CLS_RTYPE = 3'b000,
    CLS_ADD   = 3'b001,
    CLS_SUB   = 3'b010,
    CLS_OR    = 3'b011,
    CLS_AND   = 3'b100,
    CLS_LUI   = 3'b101
  } alu_class_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  alu_oper_e             w_dec_op;
  logic                  w_dec_illegal;

  logic                  r_valid;
  alu_oper_e             r_op;
  logic                  r_illegal;
  logic [4:0]            r_shamt;
  logic                  r_alu_src;
  logic [DATA_WIDTH-1:0] r_rs;
  logic [DATA_WIDTH-1:0] r_rt;
  logic [DATA_WIDTH-1:0] r_imm;

  logic [DATA_WIDTH-1:0] w_fwd_a;
  logic [DATA_WIDTH-1:0] w_fwd_b;

  // ID-side decode of ALUOp and funct.
  always_comb begin
    w_dec_op      = OP_NOP;
    w_dec_illegal = 1'b0;
    case (bus.alu_op_i)
      CLS_RTYPE: begin
        case (bus.funct_i)
          6'h20:   w_dec_op = OP_ADD;
          6'h22:   w_dec_op = OP_SUB;
          6'h24:   w_dec_op = OP_AND;
          6'h25:   w_dec_op = OP_OR;
          6'h27:   w_dec_op = OP_NOR;
          6'h00:   w_dec_op = OP_SLL;
          6'h02:   w_dec_op = OP_SRL;
          default: begin
            w_dec_op      = OP_NOP;
            w_dec_illegal = 1'b1;
          end
        endcase
      end
      CLS_ADD: w_dec_op = OP_ADD;
      CLS_SUB: w_dec_op = OP_SUB;
      CLS_OR:  w_dec_op = OP_OR;
      CLS_AND: w_dec_op = OP_AND;
      CLS_LUI: w_dec_op = OP_LUI;
      default: begin
        w_dec_op      = OP_NOP;
        w_dec_illegal = 1'b1;
      end
    endcase
  end

  // EX registers. A flush overrides a stall. An invalid ID slot loads as a NOP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid   <= 1'b0;
      r_op      <= OP_NOP;
      r_illegal <= 1'b0;
      r_shamt   <= '0;
      r_alu_src <= 1'b0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_imm     <= '0;
    end else if (bus.flush_i) begin
      r_valid   <= 1'b0;
      r_op      <= OP_NOP;
      r_illegal <= 1'b0;
      r_shamt   <= '0;
      r_alu_src <= 1'b0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_imm     <= '0;
    end else if (!bus.stall_i) begin
      r_valid   <= bus.id_valid_i;
      r_op      <= bus.id_valid_i ? w_dec_op : OP_NOP;
      r_illegal <= bus.id_valid_i & w_dec_illegal;
      r_shamt   <= bus.shamt_i;
      r_alu_src <= bus.alu_src_i;
      r_rs      <= bus.rs_data_i;
      r_rt      <= bus.rt_data_i;
      r_imm     <= bus.imm_i;
    end
  end

  // The bypass muxes sit after the EX registers, so a stalled instruction
  // still picks up bypass values that change while it waits.
  always_comb begin
    case (bus.fwd_a_sel_i)
      FWD_EXMEM: w_fwd_a = bus.exmem_result_i;
      FWD_MEMWB: w_fwd_a = bus.memwb_result_i;
      default:   w_fwd_a = r_rs;
    endcase
  end

  always_comb begin
    case (bus.fwd_b_sel_i)
      FWD_EXMEM: w_fwd_b = bus.exmem_result_i;
      FWD_MEMWB: w_fwd_b = bus.memwb_result_i;
      default:   w_fwd_b = r_rt;
    endcase
  end

  // Operand outputs are forced to zero while reset is held, even with live bypass inputs.
  always_comb begin
    bus.alu_a_o      = '0;
    bus.alu_b_o      = '0;
    bus.store_data_o = '0;
    if (reset) begin
      bus.alu_a_o      = w_fwd_a;
      bus.alu_b_o      = r_alu_src ? r_imm : w_fwd_b;
      bus.store_data_o = w_fwd_b;
    end
  end

  assign bus.ex_valid_o      = r_valid;
  assign bus.alu_operation_o = OP_WIDTH'(r_op);
  assign bus.alu_shamt_o     = r_shamt;
  assign bus.illegal_op_o    = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage. Each task drives one scenario and checks
// the results against hand-computed values.
module tb_alu_issue_stage;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  alu_issue_stage_if #(.DATA_WIDTH(32), .OP_WIDTH(4)) bus ();

  alu_issue_stage #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.id_valid_i     = 1'b0;
    bus.stall_i        = 1'b0;
    bus.flush_i        = 1'b0;
    bus.alu_op_i       = 3'b000;
    bus.funct_i        = 6'h00;
    bus.shamt_i        = 5'd0;
    bus.alu_src_i      = 1'b0;
    bus.rs_data_i      = '0;
    bus.rt_data_i      = '0;
    bus.imm_i          = '0;
    bus.fwd_a_sel_i    = 2'b00;
    bus.fwd_b_sel_i    = 2'b00;
    bus.exmem_result_i = '0;
    bus.memwb_result_i = '0;
  endtask

  task automatic test_reset();
    reset              = 1'b0;
    bus.id_valid_i     = 1'b1;
    bus.stall_i        = 1'b0;
    bus.flush_i        = 1'b0;
    bus.alu_op_i       = 3'($urandom_range(0, 7));
    bus.funct_i        = 6'($urandom);
    bus.shamt_i        = 5'($urandom);
    bus.alu_src_i      = 1'($urandom);
    bus.rs_data_i      = $urandom;
    bus.rt_data_i      = $urandom;
    bus.imm_i          = $urandom;
    bus.fwd_a_sel_i    = 2'($urandom);
    bus.fwd_b_sel_i    = 2'($urandom);
    bus.exmem_result_i = $urandom;
    bus.memwb_result_i = $urandom;
    step();
    step();
    checks++;
    if (bus.ex_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got=%b exp=0", bus.ex_valid_o);
    end
    checks++;
    if (bus.alu_operation_o !== 4'hF) begin
      errors++;
      $display("FAIL reset_op got=%h exp=f", bus.alu_operation_o);
    end
    checks++;
    if (bus.alu_a_o !== 32'h0 || bus.alu_b_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_ab got a=%h b=%h exp 0/0", bus.alu_a_o, bus.alu_b_o);
    end
    checks++;
    if (bus.illegal_op_o !== 1'b0 || bus.alu_shamt_o !== 5'd0) begin
      errors++;
      $display("FAIL reset_misc got ill=%b shamt=%0d exp 0/0", bus.illegal_op_o, bus.alu_shamt_o);
    end
    idle_inputs();
    reset          = 1'b1;
    bus.id_valid_i = 1'b1;
    bus.alu_op_i   = 3'b000;
    bus.funct_i    = 6'h22;
    step();
    checks++;
    if (bus.alu_operation_o !== 4'h4 || bus.ex_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got op=%h v=%b exp op=4 v=1", bus.alu_operation_o, bus.ex_valid_o);
    end
  endtask

  task automatic test_decode();
    logic [2:0] t_op    [15];
    logic [5:0] t_funct [15];
    logic       t_valid [15];
    logic [3:0] t_exp   [15];
    logic       t_ill   [15];
    t_op = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
             3'd0, 3'd6, 3'd0};
    t_funct = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02, 6'h3F, 6'h3F, 6'h3F,
                6'h3F, 6'h3F, 6'h18, 6'h20, 6'h18};
    t_valid = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                1'b1, 1'b1, 1'b0};
    t_exp = '{4'h3, 4'h4, 4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h3, 4'h4, 4'h1, 4'h0, 4'h5,
              4'hF, 4'hF, 4'hF};
    t_ill = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 15; i++) begin
      bus.id_valid_i = t_valid[i];
      bus.alu_op_i   = t_op[i];
      bus.funct_i    = t_funct[i];
      step();
      checks++;
      if (bus.alu_operation_o !== t_exp[i] || bus.illegal_op_o !== t_ill[i]
          || bus.ex_valid_o !== t_valid[i]) begin
        errors++;
        $display("FAIL decode_%0d got op=%h ill=%b v=%b exp op=%h ill=%b v=%b", i,
                 bus.alu_operation_o, bus.illegal_op_o, bus.ex_valid_o,
                 t_exp[i], t_ill[i], t_valid[i]);
      end
    end
  endtask

  task automatic test_stall();
    idle_inputs();
    bus.id_valid_i = 1'b1;
    bus.alu_op_i   = 3'b001;
    bus.rs_data_i  = 32'd5;
    bus.rt_data_i  = 32'd7;
    step();
    bus.stall_i   = 1'b1;
    bus.alu_op_i  = 3'b010;
    bus.rs_data_i = 32'd9;
    bus.rt_data_i = 32'd11;
    for (int i = 0; i < 3; i++) begin
      bus.shamt_i = 5'(i + 3);
      step();
      checks++;
      if (bus.alu_operation_o !== 4'h3 || bus.alu_a_o !== 32'd5 || bus.alu_b_o !== 32'd7
          || bus.ex_valid_o !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold_%0d got op=%h a=%0d b=%0d v=%b exp op=3 a=5 b=7 v=1", i,
                 bus.alu_operation_o, bus.alu_a_o, bus.alu_b_o, bus.ex_valid_o);
      end
    end
    bus.fwd_a_sel_i    = 2'b01;
    bus.exmem_result_i = 32'hCAFE_0001;
    #1;
    checks++;
    if (bus.alu_a_o !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL stall_fwd got=%h exp=cafe0001", bus.alu_a_o);
    end
    bus.fwd_a_sel_i = 2'b00;
    bus.flush_i     = 1'b1;
    step();
    checks++;
    if (bus.ex_valid_o !== 1'b0 || bus.alu_operation_o !== 4'hF || bus.alu_a_o !== 32'h0) begin
      errors++;
      $display("FAIL stall_flush got v=%b op=%h a=%h exp v=0 op=f a=0",
               bus.ex_valid_o, bus.alu_operation_o, bus.alu_a_o);
    end
    bus.flush_i = 1'b0;
    bus.stall_i = 1'b0;
  endtask

  task automatic test_forwarding();
    idle_inputs();
    bus.id_valid_i = 1'b1;
    bus.alu_op_i   = 3'b001;
    bus.rs_data_i  = 32'd1;
    bus.rt_data_i  = 32'd2;
    bus.imm_i      = 32'hFFFF_FFF0;
    step();
    bus.fwd_a_sel_i    = 2'b01;
    bus.exmem_result_i = 32'hDEAD_BEEF;
    bus.fwd_b_sel_i    = 2'b10;
    bus.memwb_result_i = 32'h1234_5678;
    #1;
    checks++;
    if (bus.alu_a_o !== 32'hDEAD_BEEF || bus.alu_b_o !== 32'h1234_5678) begin
      errors++;
      $display("FAIL fwd_ab got a=%h b=%h exp deadbeef/12345678", bus.alu_a_o, bus.alu_b_o);
    end
    bus.fwd_a_sel_i = 2'b11;
    #1;
    checks++;
    if (bus.alu_a_o !== 32'd1) begin
      errors++;
      $display("FAIL fwd_reserved got=%h exp=1", bus.alu_a_o);
    end
    bus.alu_src_i = 1'b1;
    step();
    checks++;
    if (bus.alu_b_o !== 32'hFFFF_FFF0 || bus.store_data_o !== 32'h1234_5678) begin
      errors++;
      $display("FAIL fwd_imm got b=%h sd=%h exp fffffff0/12345678", bus.alu_b_o, bus.store_data_o);
    end
  endtask

  task automatic test_shift();
    idle_inputs();
    bus.id_valid_i = 1'b1;
    bus.alu_op_i   = 3'b000;
    bus.funct_i    = 6'h00;
    bus.shamt_i    = 5'd4;
    bus.rt_data_i  = 32'h1;
    step();
    checks++;
    if (bus.alu_operation_o !== 4'h6 || bus.alu_shamt_o !== 5'd4 || bus.alu_b_o !== 32'h1) begin
      errors++;
      $display("FAIL shift got op=%h sh=%0d b=%h exp op=6 sh=4 b=1",
               bus.alu_operation_o, bus.alu_shamt_o, bus.alu_b_o);
    end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    bus.id_valid_i = 1'b1;
    bus.alu_op_i   = 3'b010;
    bus.rs_data_i  = 32'h55;
    step();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.ex_valid_o !== 1'b0 || bus.alu_operation_o !== 4'hF || bus.alu_a_o !== 32'h0) begin
      errors++;
      $display("FAIL async_reset got v=%b op=%h a=%h exp v=0 op=f a=0",
               bus.ex_valid_o, bus.alu_operation_o, bus.alu_a_o);
    end
    step();
    reset          = 1'b1;
    bus.alu_op_i   = 3'b101;
    bus.rs_data_i  = 32'h77;
    step();
    checks++;
    if (bus.alu_operation_o !== 4'h5 || bus.ex_valid_o !== 1'b1 || bus.alu_a_o !== 32'h77) begin
      errors++;
      $display("FAIL async_release got op=%h v=%b a=%h exp op=5 v=1 a=77",
               bus.alu_operation_o, bus.ex_valid_o, bus.alu_a_o);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    idle_inputs();
    test_reset();
    test_decode();
    test_stall();
    test_forwarding();
    test_shift();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage on the producer side of the 32-bit ALU.
- Each cycle it:
  - decodes main-control ALUOp plus the R-type funct field into the ALU's 4-bit ALUOperation code;
  - registers the operands, immediate and shamt;
  - applies EX-stage forwarding to produce the final A/B presented to the ALU.
- Stall and flush handshakes come from the hazard unit.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- OP_WIDTH, 4, ALUOperation width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid_i  in  1  ID stage holds a real instruction.
- stall_i  in  1  hold EX register contents.
- flush_i  in  1  replace EX contents with a bubble.
- alu_op_i  in  3  main-control class: 000 R-type, 001 ADD, 010 SUB, 011 OR, 100 AND, 101 LUI; 110 and 111 illegal.
- funct_i  in  6  instruction[5:0].
- shamt_i  in  5  instruction[10:6].
- alu_src_i  in  1  1 = B comes from immediate.
- rs_data_i  in  DATA_WIDTH  register-file read 1.
- rt_data_i  in  DATA_WIDTH  register-file read 2.
- imm_i  in  DATA_WIDTH  sign/zero-extended immediate.
- fwd_a_sel_i  in  2  00 reg, 01 EX/MEM, 10 MEM/WB, 11 reserved (acts as 00).
- fwd_b_sel_i  in  2  same encoding; ignored when registered alu_src = 1.
- exmem_result_i  in  DATA_WIDTH  EX/MEM forwarding value.
- memwb_result_i  in  DATA_WIDTH  MEM/WB forwarding value.
- ex_valid_o  out  1  EX stage holds a real instruction.
- alu_operation_o  out  OP_WIDTH  registered ALUOperation.
- alu_a_o  out  DATA_WIDTH  forwarded A (combinational from EX regs and bypass inputs).
- alu_b_o  out  DATA_WIDTH  forwarded B or registered immediate.
- alu_shamt_o  out  5  registered shamt.
- store_data_o  out  DATA_WIDTH  forwarded rt, for sw, independent of alu_src.
- illegal_op_o  out  1  registered: decoded operation unsupported.

Behaviour:
- ALUOperation codes are fixed: AND 0000, OR 0001, NOR 0010, ADD 0011, SUB 0100, LUI 0101, SLL 0110, SRL 0111, NOP 1111 (ALU returns 0).
- R-type funct decode:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x00 SLL, 0x02 SRL.
  - Any other funct gives NOP with illegal = 1.
- Non-R-type alu_op decodes directly to the matching code; 110/111 give NOP with illegal = 1.
- Decode is combinational in ID; every result is captured at the rising clk edge. Latency is one cycle from ID inputs to alu_operation_o / ex_valid_o.
- Per-edge priority:
  1. reset low (async, immediate): ex_valid_o = 0, alu_operation_o = 1111, illegal_op_o = 0, shamt = 0, all data registers = 0, alu_src = 0.
  2. flush_i = 1: load a bubble (valid 0, op 1111, illegal 0, data registers cleared). Flush wins over stall.
  3. stall_i = 1: all EX registers hold their values.
  4. Otherwise, load from ID. ex_valid = id_valid_i. If id_valid_i = 0, op is forced to 1111 and illegal to 0.
- illegal_op_o is only asserted while ex_valid_o = 1.
- Forwarding muxes are combinational after the EX registers, so the same-cycle exmem/memwb values reach alu_a_o/alu_b_o.
- While stalled, forwarding is re-evaluated every cycle, so updated bypass values propagate even though the EX registers hold.
- alu_b_o = registered imm when registered alu_src = 1; otherwise the forwarded rt.
- Reset deasserted mid-stream: the first edge after release loads normally; there is no residual state.

Test Plan:
- Reset low with random inputs -> ex_valid_o = 0, alu_operation_o = 1111, alu_a_o = alu_b_o = 0. After release, id_valid = 1, alu_op = 000, funct = 0x22 -> next cycle op = 0100, valid = 1.
- Full decode sweep: each supported funct and alu_op 001–101 -> codes 0011/0100/0000/0001/0010/0110/0111/0011/0100/0001/0000/0101. funct = 0x18 -> op 1111, illegal_op_o = 1.
- Stall: load add with rs = 5, rt = 7, then stall 3 cycles while ID changes -> outputs hold op 0011, A = 5, B = 7. Simultaneous stall + flush -> bubble (valid 0, op 1111).
- Forwarding: fwd_a_sel = 01, exmem = 0xDEADBEEF; fwd_b_sel = 10, memwb = 0x12345678 -> alu_a_o / alu_b_o match these values the same cycle. With alu_src = 1 and imm = 0xFFFF_FFF0 -> alu_b_o = 0xFFFF_FFF0 and store_data_o = 0x12345678.
- Shift: alu_op = 000, funct = 0x00, shamt = 4, rt = 0x1 -> op 0110, alu_shamt_o = 4, alu_b_o = 0x1.
- Asynchronous reset asserted between clock edges while valid = 1 -> outputs clear immediately, without waiting for a clock edge.
